tff_mod_counter: RTL and testbench
==================================

Name: tff_mod_counter

Overview:
- Synchronous modulo-MOD up/down counter built as a bank of T flip-flop cells.
- Downstream consumer of the toggle flip-flop stage: per-bit T inputs are derived from the current count and the requested next count.
- Output serves as a timebase/sequence index for sequential test designs.
- Provides an enable, a parallel load, a direction select and a terminal-count flag.

Parameters:
- WIDTH, 4, count width in bits; legal range 1..16.
- MOD, 10, modulus; count sequence is 0..MOD-1; legal range 2..2^WIDTH (elaboration-time check, $error if violated).

Ports:
- Clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately on assertion, independent of Clk.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count (registered; sourced from the cell Q outputs).
- tc  output  1  terminal count; combinational; high in the cycle whose next edge wraps.

Behaviour:
- Reset:
  - rst=1 forces count=0 asynchronously, with no wait for Clk.
  - While rst is held, count stays 0 and tc=0.
  - Release is asynchronous; the first counting edge is the first posedge with rst=0.
- Priority at each posedge: rst > load > en > hold.
- Load (load=1):
  - count <= load_val if load_val < MOD, else count <= MOD-1 (clamp).
  - en and up are ignored in that cycle.
- Count (en=1, load=0):
  - up=1: count <= (count==MOD-1) ? 0 : count+1.
  - up=0: count <= (count==0) ? MOD-1 : count-1.
  - Latency: one edge per step, and the new value is visible right after the edge.
- Hold (en=0, load=0): count unchanged and all T inputs are 0.
- Structure:
  - next_count is computed combinationally.
  - Toggle vector T[i] = count[i] ^ next_count[i].
  - Each bit is one tff_cell, so every state change is expressed as toggles, never as a direct D write.
- tc:
  - tc = en & ~load & ~rst & (up ? count==MOD-1 : count==0).
  - tc is glitch-tolerant but not registered; consumers sample it on Clk.
- Out-of-range state: if count >= MOD (only reachable via X/fault injection), the next counting edge goes to 0 in either direction, and tc=0 in that state.
- Direction change mid-sequence takes effect on the next edge, with no extra latency.
- Reset asserted mid-count aborts the sequence. There is no memory of direction or load, and the count restarts from 0.
- X on en/up/load while rst=0 is a bench error; there is no RTL masking.

Decomposition:
- Shared package tff_pkg:
  - localparam-style constants for the default WIDTH/MOD.
  - A function mod_next(count, up, MOD) returning next_count, reused by the bench reference model.
- Sub-module tff_cell: 1-bit T flip-flop.
  - Ports Clk, rst (async active-high), T, Q, nQ.
  - Q toggles on posedge when T=1; Q=0 and nQ=1 on reset.
  - nQ is always the complement of the current Q, not the previous one.
- Top:
  - Generate loop instantiating WIDTH cells.
  - next-count/clamp logic.
  - tc logic.

Test Plan:
- Reset then count up: rst=1 for 2 cycles, release, en=1, up=1 for 12 edges -> count goes 0,1,...,9,0,1,2; tc=1 only while count=9.
- Count down from reset: en=1, up=0 -> count goes 0,9,8,...; tc=1 while count=0 before the 0->9 edge.
- Load priority: count=3, load=1, load_val=7, en=1, up=1 on the same edge -> count=7 (not 4); next edge with load=0 -> 8.
- Load clamp: load_val=12 with MOD=10 -> count=9. Then en=1, up=1 -> 0 with tc=1 in the preceding cycle.
- Hold: en=0 for 5 edges at count=5 -> count stays 5, tc=0, and all internal T=0 (probe).
- Async reset mid-count:
  - Sequence at count=6: assert rst 2 time units after a posedge -> count=0 before the next edge.
  - Release rst 3 time units before a posedge with en=1, up=1 -> count=1 after that edge.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared constants and next-state helper for the T-flip-flop modulo counter.
package tff_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_MOD   = 10;

    // Next count for one enabled step; an out-of-range value recovers to 0.
    function automatic logic [15:0] mod_next(input logic [15:0] cur,
                                             input logic        up,
                                             input int unsigned modulus);
        logic [15:0] res;
        res = '0;
        if (32'(cur) >= modulus) begin
            res = '0;
        end else if (up) begin
            res = (32'(cur) == modulus - 1) ? '0 : cur + 16'd1;
        end else begin
            res = (cur == '0) ? 16'(modulus - 1) : cur - 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// One-bit T flip-flop with asynchronous active-high reset; nQ tracks the current Q.
module tff_cell (
    input  logic Clk,
    input  logic rst,
    input  logic T,
    output logic Q,
    output logic nQ
);

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            Q <= 1'b0;
        end else if (T) begin
            Q <= ~Q;
        end
    end

    assign nQ = ~Q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MOD up/down counter with load and terminal count, built from T flip-flop cells.
module tff_mod_counter
    import tff_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned MOD   = DEFAULT_MOD
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("tff_mod_counter: WIDTH %0d outside 1..16", WIDTH);
    end
    if (MOD < 2 || MOD > (32'd1 << WIDTH)) begin : g_bad_mod
        $error("tff_mod_counter: MOD %0d outside 2..2^WIDTH", MOD);
    end

    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] nq_vec;

    always_comb begin
        next_count = count;
        if (load) begin
            if ({1'b0, load_val} < MOD_W) begin
                next_count = load_val;
            end else begin
                next_count = LAST;
            end
        end else if (en) begin
            next_count = WIDTH'(mod_next(16'(count), up, MOD));
        end
    end

    // State only ever changes by toggling the bits that differ.
    assign t_vec = count ^ next_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .Clk (Clk),
            .rst (rst),
            .T   (t_vec[i]),
            .Q   (count[i]),
            .nQ  (nq_vec[i])
        );
    end

    // All nQ high means count is zero.
    assign tc = en & ~load & ~rst & (up ? (count == LAST) : (&nq_vec));

endmodule

// File: tb/tb_tff_mod_counter.sv
// Self-checking bench for tff_mod_counter against an arithmetic reference model.
module tb_tff_mod_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             Clk;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;

    int errors = 0;
    int checks = 0;
    int model  = 0;

    tff_mod_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .Clk      (Clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic int model_next(int cur, logic l, int lv, logic e, logic u);
        if (l) return (lv < MOD) ? lv : MOD - 1;
        if (!e) return cur;
        if (u) return (cur + 1) % MOD;
        return (cur + MOD - 1) % MOD;
    endfunction

    function automatic logic model_tc(int cur, logic l, logic e, logic u);
        return e && !l && (u ? (cur == MOD - 1) : (cur == 0));
    endfunction

    // Inputs are already applied; check tc mid-cycle, take one edge, check count.
    task automatic step(input string name);
        logic             exp_tc;
        logic [WIDTH-1:0] exp_cnt;
        @(negedge Clk);
        exp_tc = model_tc(model, load, en, up);
        checks++;
        if (tc !== exp_tc) begin
            errors++;
            $display("FAIL %s tc: got %b expected %b (model count %0d)", name, tc, exp_tc, model);
        end
        @(posedge Clk);
        #1;
        model   = model_next(model, load, int'(load_val), en, up);
        exp_cnt = WIDTH'(model);
        checks++;
        if (count !== exp_cnt) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, count, exp_cnt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        rst   = 1'b0;
        model = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; load_val = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc: got %b expected 0", tc);
        end
        @(posedge Clk);
        #1;
        rst   = 1'b0;
        model = 0;
    endtask

    task automatic test_count_up();
        do_reset();
        en = 1'b1; up = 1'b1; load = 1'b0;
        for (int i = 0; i < 12; i++) step("count_up");
    endtask

    task automatic test_count_down();
        do_reset();
        en = 1'b1; up = 1'b0; load = 1'b0;
        for (int i = 0; i < 12; i++) step("count_down");
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 4'd3; en = 1'b0;
        step("load_3");
        load = 1'b1; load_val = 4'd7; en = 1'b1; up = 1'b1;
        step("load_over_en");
        load = 1'b0;
        step("after_load");
    endtask

    task automatic test_load_clamp();
        load = 1'b1; load_val = 4'd12; en = 1'b1; up = 1'b1;
        step("load_clamp");
        load = 1'b0; load_val = 4'd15;
        step("clamp_wrap");
        load = 1'b1; load_val = 4'd15;
        step("load_clamp_max");
    endtask

    task automatic test_hold();
        load = 1'b1; load_val = 4'd5;
        step("hold_load");
        load = 1'b0; en = 1'b0; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checks++;
            if (dut.t_vec !== '0) begin
                errors++;
                $display("FAIL hold_t_vec: got %b expected 0000", dut.t_vec);
            end
            step("hold");
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 4'd6; en = 1'b1; up = 1'b1;
        step("pre_reset_load");
        load = 1'b0;
        @(posedge Clk);
        model = model_next(model, 1'b0, 0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model = 0;
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL async_assert count: got %0d expected 0", count);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL async_assert tc: got %b expected 0", tc);
        end
        @(posedge Clk);
        #7;
        rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0;
        @(posedge Clk);
        #1;
        checks++;
        if (count !== 4'd1) begin
            errors++;
            $display("FAIL async_release count: got %0d expected 1", count);
        end
        model = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            en       = $urandom_range(0, 3) != 0;
            up       = $urandom_range(0, 1) != 0;
            load     = $urandom_range(0, 7) == 0;
            load_val = WIDTH'($urandom_range(0, 15));
            step("random");
        end
    endtask

    task automatic test_back_to_back();
        en = 1'b1; load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            up = (i % 3) != 0;
            step("dir_switch");
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_priority();
        test_load_clamp();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
